vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter_pkg.sv | 32 +++
 rtl/vga_fb_arbiter_addr_gen.sv | 43 ++++
 rtl/vga_fb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants, arbiter state type and the line-base helper used by the
// framebuffer arbiter and its address generator.
package vga_pkg;
  localparam int H_ACT           = 640;
  localparam int V_ACT           = 480;
  localparam int FB_DEPTH        = H_ACT * V_ACT;
  localparam int DW_DEF          = 24;
  localparam int AW_DEF          = 19;
  localparam int FETCH_BURST_DEF = 16;
  localparam int XW              = 10;
  localparam int YW              = 10;
  localparam logic [31:0] H_ACT_VEC = 32'(H_ACT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOST  = 2'd2
  } arb_state_e;

  typedef logic [DW_DEF-1:0] pixel_t;

  // y*H_ACT as a sum of shifted copies of y, one per set bit of H_ACT
  function automatic logic [31:0] line_base(input logic [YW-1:0] y);
    logic [31:0] acc;
    acc = 32'd0;
    for (int b = 0; b < 32; b++) begin
      if (H_ACT_VEC[b]) acc = acc + ({{(32-YW){1'b0}}, y} << b);
      else              acc = acc;
    end
    return acc;
  endfunction
endpackage

// File: rtl/vga_fb_arbiter_addr_gen.sv
// Line fetch address generator: latches the line base address and steps the
// pixel counter across one active line.
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic [XW-1:0] x,
  output logic          last
);
  logic [AW-1:0] base_r;
  logic [XW-1:0] x_r;
  logic          last_s;

  assign last_s = (x_r == XW'(H_ACT - 1));

  // load restarts the line at x=0 and takes priority over stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= {AW{1'b0}};
      x_r    <= {XW{1'b0}};
    end else if (load) begin
      base_r <= AW'(line_base(y));
      x_r    <= {XW{1'b0}};
    end else if (advance) begin
      base_r <= base_r;
      x_r    <= last_s ? {XW{1'b0}} : x_r + XW'(1);
    end else begin
      base_r <= base_r;
      x_r    <= x_r;
    end
  end

  assign addr = base_r + {{(AW-XW){1'b0}}, x_r};
  assign x    = x_r;
  assign last = last_s;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: line prefetch into a ping-pong line buffer
// has priority, host pixel writes fill gaps and a forced slot every burst.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int FETCH_BURST = FETCH_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic [9:0]    line_y,
  input  logic          line_bank,
  input  logic          host_valid,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_ready,
  output logic          host_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lb_we,
  output logic [10:0]   lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          fetch_done,
  output logic          fetch_overrun
);
  localparam int BW = (FETCH_BURST > 1) ? $clog2(FETCH_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(FETCH_BURST - 1);

  arb_state_e    state_r, state_s;
  logic [BW-1:0] burst_r, burst_s;
  logic          active_r, active_s;
  logic          bank_r;
  logic          load_s, advance_s, overrun_s;
  logic          start_s, in_range_s;
  logic [AW-1:0] fetch_addr_s;
  logic [XW-1:0] x_s;
  logic          last_s;
  logic          lb_we_r, fetch_done_r, fetch_overrun_r;
  logic [10:0]   lb_addr_r;

  assign start_s    = line_start && (line_y < YW'(V_ACT));
  assign in_range_s = (host_addr < AW'(FB_DEPTH));

  vga_fb_addr_gen #(.AW(AW)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .advance (advance_s),
    .y       (line_y),
    .addr    (fetch_addr_s),
    .x       (x_s),
    .last    (last_s)
  );

  // Arbiter state, burst counter, fetch-in-progress flag and target bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      burst_r  <= {BW{1'b0}};
      active_r <= 1'b0;
      bank_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      burst_r  <= burst_s;
      active_r <= active_s;
      bank_r   <= load_s ? line_bank : bank_r;
    end
  end

  // Next-state decision; a line issuing its last read is complete, not overrun
  always_comb begin
    state_s   = state_r;
    burst_s   = burst_r;
    active_s  = active_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    overrun_s = line_start && active_r && !((state_r == FETCH) && last_s);
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s  = FETCH;
          load_s   = 1'b1;
          burst_s  = {BW{1'b0}};
          active_s = 1'b1;
        end else if (host_valid) begin
          state_s = HOST;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        advance_s = 1'b1;
        if (start_s) begin
          state_s  = FETCH;
          load_s   = 1'b1;
          burst_s  = {BW{1'b0}};
          active_s = 1'b1;
        end else if (line_start || last_s) begin
          state_s  = host_valid ? HOST : IDLE;
          burst_s  = {BW{1'b0}};
          active_s = 1'b0;
        end else if (burst_r == BURST_LAST) begin
          state_s = host_valid ? HOST : FETCH;
          burst_s = {BW{1'b0}};
        end else begin
          burst_s = burst_r + BW'(1);
        end
      end
      HOST: begin
        if (start_s) begin
          state_s  = FETCH;
          load_s   = 1'b1;
          burst_s  = {BW{1'b0}};
          active_s = 1'b1;
        end else if (line_start && active_r) begin
          state_s  = host_valid ? HOST : IDLE;
          active_s = 1'b0;
        end else if (active_r) begin
          state_s = FETCH;
        end else if (host_valid) begin
          state_s = HOST;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        burst_s  = {BW{1'b0}};
        active_s = 1'b0;
      end
    endcase
  end

  // RAM port mux; host outputs follow the live request so writes can stream
  always_comb begin
    mem_addr   = {AW{1'b0}};
    mem_we     = 1'b0;
    mem_wdata  = {DW{1'b0}};
    host_ready = 1'b0;
    host_err   = 1'b0;
    case (state_r)
      FETCH: begin
        mem_addr = fetch_addr_s;
      end
      HOST: begin
        mem_addr   = host_addr;
        mem_wdata  = host_data;
        mem_we     = host_valid && in_range_s;
        host_ready = host_valid;
        host_err   = host_valid && !in_range_s;
      end
      default: begin
        mem_addr = {AW{1'b0}};
      end
    endcase
  end

  // Read-return pipeline, aligned with the one-cycle RAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      lb_we_r         <= 1'b0;
      lb_addr_r       <= 11'd0;
      fetch_done_r    <= 1'b0;
      fetch_overrun_r <= 1'b0;
    end else begin
      lb_we_r         <= (state_r == FETCH);
      lb_addr_r       <= {bank_r, x_s};
      fetch_done_r    <= (state_r == FETCH) && last_s;
      fetch_overrun_r <= overrun_s;
    end
  end

  assign lb_we         = lb_we_r;
  assign lb_addr       = lb_addr_r;
  assign lb_wdata      = lb_we_r ? mem_rdata : {DW{1'b0}};
  assign fetch_done    = fetch_done_r;
  assign fetch_overrun = fetch_overrun_r;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: pattern RAM model, host request driver,
// line-buffer and host-accept scoreboards.
module tb_vga_fb_arbiter;
  typedef struct {
    logic [10:0] addr;
    logic [23:0] data;
  } lb_exp_t;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    logic        oor;
  } hreq_t;

  logic        clk;
  logic        rst;
  logic        line_start;
  logic [9:0]  line_y;
  logic        line_bank;
  logic        host_valid;
  logic [18:0] host_addr;
  logic [23:0] host_data;
  logic        host_ready;
  logic        host_err;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        lb_we;
  logic [10:0] lb_addr;
  logic [23:0] lb_wdata;
  logic        fetch_done;
  logic        fetch_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int st_cyc = 0;
  lb_exp_t lb_q[$];
  hreq_t   hreq_q[$];

  int lb_cnt = 0, done_cnt = 0, done_cyc = 0, ovr_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int lb_rise_cyc = 0;
  logic acc_flag = 1'b0;
  logic prev_lb_we = 1'b0;

  vga_fb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .line_start    (line_start),
    .line_y        (line_y),
    .line_bank     (line_bank),
    .host_valid    (host_valid),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .host_err      (host_err),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_wdata      (lb_wdata),
    .fetch_done    (fetch_done),
    .fetch_overrun (fetch_overrun)
  );

  function automatic logic [23:0] pat(input logic [18:0] a);
    return {5'h15, a ^ 19'h2A5A5};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int y, input logic bank, input int npush);
    lb_exp_t e;
    for (int x = 0; x < npush; x++) begin
      e.addr = {bank, 10'(x)};
      e.data = pat(19'(y * 640 + x));
      lb_q.push_back(e);
    end
    line_y     = 10'(y);
    line_bank  = bank;
    line_start = 1'b1;
    st_cyc     = cyc;
  endtask

  task automatic push_host(input logic [18:0] a, input logic [23:0] d);
    hreq_t h;
    h.addr = a;
    h.data = d;
    h.oor  = (a >= 19'd307200);
    hreq_q.push_back(h);
  endtask

  task automatic wait_done(input string tag, input int base_cnt, input int budget);
    int n;
    n = 0;
    while (done_cnt == base_cnt && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(done_cnt != base_cnt), 32'd1);
  endtask

  task automatic wait_host_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (hreq_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, 32'(hreq_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    check_eq({tag, "_host_err"}, 32'(host_err), 32'd0);
    check_eq({tag, "_lb_we"}, 32'(lb_we), 32'd0);
    check_eq({tag, "_lb_addr"}, 32'(lb_addr), 32'd0);
    check_eq({tag, "_lb_wdata"}, 32'(lb_wdata), 32'd0);
    check_eq({tag, "_fetch_done"}, 32'(fetch_done), 32'd0);
    check_eq({tag, "_overrun"}, 32'(fetch_overrun), 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read data is a fixed function of the address, one cycle late
  always @(posedge clk) mem_rdata <= pat(mem_addr);

  // Host driver: holds each request until the monitor saw it accepted
  initial begin
    host_valid = 1'b0;
    host_addr  = 19'd0;
    host_data  = 24'd0;
    forever begin
      @(posedge clk);
      #2;
      if (acc_flag && hreq_q.size() != 0) void'(hreq_q.pop_front());
      if (hreq_q.size() != 0) begin
        host_valid = 1'b1;
        host_addr  = hreq_q[0].addr;
        host_data  = hreq_q[0].data;
      end else begin
        host_valid = 1'b0;
        host_addr  = 19'd0;
        host_data  = 24'd0;
      end
    end
  end

  // Output monitor and scoreboard consumer
  initial begin
    lb_exp_t e;
    hreq_t   h;
    forever begin
      @(negedge clk);
      acc_flag = host_ready && host_valid;
      if (lb_we && !prev_lb_we) lb_rise_cyc = cyc;
      prev_lb_we = lb_we;
      if (lb_we) begin
        lb_cnt++;
        if (lb_q.size() == 0) begin
          check_eq("lb_unexpected", 32'd1, 32'd0);
        end else begin
          e = lb_q.pop_front();
          check_eq("lb_addr", 32'(lb_addr), 32'(e.addr));
          check_eq("lb_wdata", 32'(lb_wdata), 32'(e.data));
        end
      end
      if (fetch_done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("done_with_lb_we", 32'(lb_we), 32'd1);
        check_eq("done_last_x", 32'(lb_addr[9:0]), 32'd639);
      end
      if (fetch_overrun) ovr_cnt++;
      if (host_err) err_cnt++;
      if (acc_flag) begin
        acc_cnt++;
        if (hreq_q.size() == 0) begin
          check_eq("host_unexpected", 32'd1, 32'd0);
        end else begin
          h = hreq_q[0];
          check_eq("host_mem_addr", 32'(mem_addr), 32'(h.addr));
          check_eq("host_mem_wdata", 32'(mem_wdata), 32'(h.data));
          check_eq("host_mem_we", 32'(mem_we), 32'(!h.oor));
          check_eq("host_err", 32'(host_err), 32'(h.oor));
        end
      end else if (mem_we) begin
        check_eq("stray_mem_we", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int d0, a0, o0, e0, l0, n, run;
    rst        = 1'b1;
    line_start = 1'b0;
    line_y     = 10'd0;
    line_bank  = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst = 1'b0;
    step();

    // Line 0 into bank 1, no host traffic
    d0 = done_cnt;
    start_line(0, 1'b1, 640);
    step();
    line_start = 1'b0;
    @(negedge clk);
    check_eq("A_first_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("A_first_mem_we", 32'(mem_we), 32'd0);
    wait_done("A_done_seen", d0, 800);
    check_eq("A_done_cycle", 32'(done_cyc - st_cyc), 32'd641);
    check_eq("A_lb_first_cycle", 32'(lb_rise_cyc - st_cyc), 32'd2);
    check_eq("A_lb_queue_empty", 32'(lb_q.size()), 32'd0);
    repeat (4) step();

    // Last line with host requests pending from the same cycle
    d0 = done_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 44; i++) push_host(19'($urandom_range(0, 307199)), 24'($urandom));
    start_line(479, 1'b0, 640);
    step();
    line_start = 1'b0;
    @(negedge clk);
    check_eq("B_first_mem_addr", 32'(mem_addr), 32'd306560);
    n = 1;
    while (!(host_ready && host_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("B_host_latency_ok", 32'(n <= 17), 32'd1);
    wait_done("B_done_seen", d0, 800);
    check_eq("B_done_by_681", 32'((done_cyc - st_cyc) <= 681), 32'd1);
    check_eq("B_host_accepts", 32'(acc_cnt - a0), 32'd40);
    wait_host_empty("B_host_drained", 100);
    check_eq("B_lb_queue_empty", 32'(lb_q.size()), 32'd0);
    repeat (4) step();

    // Back-to-back host writes in IDLE, the middle one out of range
    e0 = err_cnt;
    push_host(19'd1000, 24'hABCDEF);
    push_host(19'd307200, 24'h123456);
    push_host(19'd307199, 24'h654321);
    n = 0;
    while (!(host_ready && host_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    run = 0;
    while (host_ready && host_valid && run < 10) begin
      run++;
      @(negedge clk);
    end
    check_eq("C_back_to_back", 32'(run), 32'd3);
    wait_host_empty("C_host_drained", 20);
    check_eq("C_err_count", 32'(err_cnt - e0), 32'd1);
    repeat (4) step();

    // Overrun: second line_start while x=300 is being issued
    d0 = done_cnt;
    o0 = ovr_cnt;
    start_line(10, 1'b0, 301);
    step();
    line_start = 1'b0;
    n = st_cyc;
    while (cyc < n + 301) step();
    start_line(20, 1'b1, 640);
    step();
    line_start = 1'b0;
    @(negedge clk);
    check_eq("D_restart_mem_addr", 32'(mem_addr), 32'd12800);
    check_eq("D_overrun_pulse", 32'(fetch_overrun), 32'd1);
    wait_done("D_done_seen", d0, 800);
    repeat (5) step();
    check_eq("D_done_count", 32'(done_cnt - d0), 32'd1);
    check_eq("D_overrun_count", 32'(ovr_cnt - o0), 32'd1);
    check_eq("D_lb_queue_empty", 32'(lb_q.size()), 32'd0);

    // Reset in the middle of a fetch discards the in-flight read
    d0 = done_cnt;
    start_line(5, 1'b0, 640);
    step();
    line_start = 1'b0;
    repeat (49) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    lb_q.delete();
    @(negedge clk);
    check_all_zero("E_after_rst");
    l0 = lb_cnt;
    repeat (6) step();
    check_eq("E_no_lb_after_rst", 32'(lb_cnt - l0), 32'd0);
    check_eq("E_no_done_after_rst", 32'(done_cnt - d0), 32'd0);

    // Line index beyond the active area is ignored
    l0 = lb_cnt;
    start_line(480, 1'b1, 0);
    step();
    line_start = 1'b0;
    @(negedge clk);
    check_eq("F_ignored_mem_addr", 32'(mem_addr), 32'd0);
    repeat (6) step();
    check_eq("F_ignored_no_lb", 32'(lb_cnt - l0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
